// File: rtl/bus_rr_sched.sv
// ---------------------------------------------------------------------------
// bus_rr_sched
//   Round-robin scheduler for the shared packet bus of the bus generator.
//   One source FIFO is granted at a time: its head packet is popped, the
//   destination byte is decoded, and the packet is pushed to one receive
//   FIFO or (broadcast) to every receive FIFO except the source. The push is
//   held while any target is full and the packet is dropped on a malformed
//   destination or after TIMEOUT consecutive stall cycles.
//
// Ports
//   clk       in   rising-edge clock for all state
//   reset     in   asynchronous active-low reset
//   pndng     in   [drvrs]          source FIFO i non-empty
//   D_pop     in   [drvrs*pckg_sz]  head data, slice i = [i*pckg_sz +: pckg_sz]
//   full      in   [drvrs]          receive FIFO i cannot accept a push
//   pop       out  [drvrs]          one-hot pop strobe to the granted source
//   push      out  [drvrs]          push strobe(s) to destination FIFO(s)
//   D_push    out  [pckg_sz]        bus data, valid while any push bit is set
//   grant_id  out  [$clog2(drvrs)]  currently granted source
//   busy      out                   high while in POP or PUSH
//   err       out                   one-cycle pulse when a packet is dropped
//   err_code  out  [2]              01 invalid destination, 10 stall timeout
// ---------------------------------------------------------------------------
module bus_rr_sched #(
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         TIMEOUT   = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [drvrs-1:0]           pndng,
   input  logic [drvrs*pckg_sz-1:0]   D_pop,
   input  logic [drvrs-1:0]           full,
   output logic [drvrs-1:0]           pop,
   output logic [drvrs-1:0]           push,
   output logic [pckg_sz-1:0]         D_push,
   output logic [$clog2(drvrs)-1:0]   grant_id,
   output logic                       busy,
   output logic                       err,
   output logic [1:0]                 err_code
);

   localparam int              IW         = $clog2(drvrs);
   // stall counter only needs to reach TIMEOUT-1: the drop happens on the
   // cycle that would have made it TIMEOUT
   localparam int              SW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0]   STALL_LAST = SW'(TIMEOUT - 1);
   localparam logic [IW-1:0]   LAST_PORT  = IW'(drvrs - 1);
   localparam logic [7:0]      NUM_PORTS  = 8'(drvrs);
   localparam logic [IW:0]     SCAN_WRAP  = (IW+1)'(drvrs);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_POP  = 2'b01,
      ST_PUSH = 2'b10
   } state_e;

   // one-hot vector with bit idx set
   function automatic logic [drvrs-1:0] onehot(input logic [IW-1:0] idx);
      logic [drvrs-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   state_e              state_q,    state_d;
   logic [IW-1:0]       grant_q,    grant_d;
   logic [IW-1:0]       rr_ptr_q,   rr_ptr_d;
   logic [drvrs-1:0]    tgt_q,      tgt_d;
   logic [pckg_sz-1:0]  pkt_q,      pkt_d;
   logic [SW-1:0]       stall_q,    stall_d;
   logic                err_q,      err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic                found_s;
   logic [IW-1:0]       sel_s;
   logic [IW:0]         scan_s;
   logic [pckg_sz-1:0]  pkt_s;
   logic [7:0]          dest_s;
   logic [drvrs-1:0]    tgt_s;
   logic                stall_s;
   logic [IW-1:0]       next_ptr_s;

   // round-robin pick: first pending port at or above rr_ptr, wrapping to 0
   always_comb begin
      found_s = 1'b0;
      sel_s   = '0;
      scan_s  = '0;
      for (int k = 0; k < drvrs; k++) begin
         scan_s = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (scan_s >= SCAN_WRAP) begin
            scan_s = scan_s - SCAN_WRAP;
         end else begin
            scan_s = scan_s;
         end
         if (!found_s && pndng[scan_s[IW-1:0]]) begin
            found_s = 1'b1;
            sel_s   = scan_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // head packet of the granted source
   always_comb begin
      pkt_s = '0;
      for (int i = 0; i < drvrs; i++) begin
         if (grant_q == IW'(i)) begin
            pkt_s = D_pop[i*pckg_sz +: pckg_sz];
         end else begin
            pkt_s = pkt_s;
         end
      end
   end

   assign dest_s = pkt_s[pckg_sz-1 -: 8];

   // destination decode; sending to yourself counts as malformed
   always_comb begin
      tgt_s = '0;
      if (dest_s == broadcast) begin
         tgt_s = ~onehot(grant_q);
      end else if ((dest_s < NUM_PORTS) && (dest_s != {{(8-IW){1'b0}}, grant_q})) begin
         tgt_s = onehot(dest_s[IW-1:0]);
      end else begin
         tgt_s = '0;
      end
   end

   // a broadcast waits for every target, so any full target blocks it
   assign stall_s    = |(tgt_q & full);
   assign next_ptr_s = (grant_q == LAST_PORT) ? '0 : grant_q + IW'(1);

   // next-state logic for the IDLE -> POP -> PUSH transfer sequence
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      tgt_d      = tgt_q;
      pkt_d      = pkt_q;
      stall_d    = stall_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               grant_d = sel_s;
               state_d = ST_POP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_POP: begin
            tgt_d = tgt_s;
            if (tgt_s == '0) begin
               state_d    = ST_IDLE;
               err_d      = 1'b1;
               err_code_d = 2'b01;
               rr_ptr_d   = next_ptr_s;
            end else begin
               state_d = ST_PUSH;
               pkt_d   = pkt_s;
               stall_d = '0;
            end
         end
         ST_PUSH: begin
            if (!stall_s) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr_s;
            end else if (stall_q == STALL_LAST) begin
               state_d    = ST_IDLE;
               err_d      = 1'b1;
               err_code_d = 2'b10;
               rr_ptr_d   = next_ptr_s;
            end else begin
               stall_d = stall_q + SW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         tgt_q      <= '0;
         pkt_q      <= '0;
         stall_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         tgt_q      <= tgt_d;
         pkt_q      <= pkt_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   // strobes decoded from the registered state; push is also masked by stall
   always_comb begin
      pop  = '0;
      push = '0;
      busy = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
         end
         ST_POP: begin
            pop  = onehot(grant_q);
            busy = 1'b1;
         end
         ST_PUSH: begin
            push = stall_s ? '0 : tgt_q;
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign D_push   = pkt_q;
   assign grant_id = grant_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin scheduler that shares the single packet bus between `drvrs` driver-side FIFOs.
- Each cycle it decides which pending FIFO is popped, decodes the destination field of the popped packet, and pushes it to one destination FIFO or, for broadcast, to all other FIFOs.
- It holds the transfer while any target is full and drops packets that are malformed or stalled too long.
- It sits between the driver FIFOs (pndng/pop/D_pop) and the receive FIFOs (push/D_push/full) of the bus generator.

Parameters:
- drvrs, 4, number of FIFO ports on the bus (2..16).
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 -: 8].
- broadcast, 8'hFF, destination ID meaning "all ports except source".
- TIMEOUT, 255, max consecutive stall cycles in PUSH before the packet is dropped (>=1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  drvrs  bit i = FIFO i non-empty; D_pop slice i valid while set.
- D_pop  in  drvrs*pckg_sz  head-of-FIFO data; slice i = [i*pckg_sz +: pckg_sz].
- full  in  drvrs  bit i = receive FIFO i cannot accept a push.
- pop  out  drvrs  one-hot pop strobe to source FIFO.
- push  out  drvrs  push strobe(s) to destination FIFO(s).
- D_push  out  pckg_sz  shared bus data, valid while any push bit is high.
- grant_id  out  $clog2(drvrs)  index of currently granted source.
- busy  out  1  high in POP or PUSH.
- err  out  1  one-cycle pulse on a dropped packet.
- err_code  out  2  01 = invalid destination, 10 = stall timeout; held until next err.

Behaviour:
- Reset (reset=0, async): state IDLE; pop/push/busy/err=0; err_code=0; D_push=0; grant_id=0; rr_ptr=0; stall_cnt=0.
- Reset mid-transfer: any packet already popped is discarded, with no push and no err.
- FSM states are IDLE, POP and PUSH. Outputs are Moore-decoded from registered state, except push, which is gated combinationally by full.
- IDLE:
  - If any pndng is set, select the first set bit scanning upward from rr_ptr with wrap at drvrs-1 -> 0.
  - Register grant_id and go to POP. Otherwise stay in IDLE.
- POP:
  - pop[grant_id]=1 for exactly one cycle.
  - Latch pkt = D_pop slice grant_id.
  - Compute targets (registered):
    - dest == broadcast -> all ones except bit grant_id.
    - dest < drvrs and dest != grant_id -> one-hot(dest).
    - otherwise -> 0.
  - If targets==0: go to IDLE, pulse err the next cycle, err_code=01, rr_ptr=grant_id+1 mod drvrs.
  - Otherwise go to PUSH with stall_cnt=0.
- PUSH:
  - D_push=pkt.
  - stall = |(targets & full).
  - If !stall: push=targets for one cycle, go to IDLE, rr_ptr=grant_id+1 mod drvrs.
  - If stall: push=0 and stall_cnt++. When stall_cnt reaches TIMEOUT, go to IDLE, pulse err, err_code=10, advance rr_ptr.
  - Broadcast is all-or-nothing; no partial pushes.
- Minimum latency: pndng seen in IDLE at cycle 0 -> pop at cycle 1 -> push at cycle 2. Peak throughput is 1 packet per 3 cycles.
- pndng is sampled only in IDLE. A pndng drop during POP/PUSH does not abort the transfer.
- D_push holds its last value outside PUSH and is don't-care for the checker there.
- Fairness: with all ports continuously pending, the grant order is 0,1,...,drvrs-1,0,...; no port waits more than drvrs-1 grants.
- Simultaneous pndng and full on the same port is legal: that port can be a source while being a blocked target of another.

Test Plan:
- Single transfer:
  - Stimulus: after reset release, pndng=4'b0001, D_pop[0]=16'h02AB, full=0.
  - Required: pop=0001 at cycle 1; push=0100 and D_push=16'h02AB at cycle 2; busy high for cycles 1–2; err=0.
- Round-robin:
  - Stimulus: all four pndng held high; packets from port i addressed to (i+1)%4.
  - Required: grant_id sequence 0,1,2,3,0 over 15 cycles; each push is one-hot at (i+1)%4.
- Broadcast with backpressure:
  - Stimulus: port 2 sends 16'hFF55; full[1]=1 for 5 cycles, then 0.
  - Required: push stays 0 for 5 PUSH cycles, then push=1011 for one cycle with D_push=16'hFF55.
- Invalid destination:
  - Stimulus 1: port 1 sends 16'h0733 (dest 7 >= 4). Required: pop[1] pulses, no push, err pulses once, err_code=01.
  - Stimulus 2: port 3 sends dest 3 (self). Required: same response as stimulus 1.
- Timeout:
  - Stimulus: TIMEOUT=8; port 0 sends to 3 with full[3] held high.
  - Required: err pulses with err_code=10 after 8 stall cycles; no push; the next grant goes to port 1 if it is pending.
- Async reset mid-transfer:
  - Stimulus: reset=0 asserted during PUSH, between clock edges.
  - Required: push/pop/busy go low immediately; grant_id=0; after release, the next grant starts at port 0.
